btn_debounce: RTL

Debounces the raw CYC1000 USER_BTN pin into a clean, synchronous button level plus single-cycle press, release and long-press events in the CLK48M domain. It sits between the pin and its consumers:
- The debounced level feeds the system reset network in place of the raw pin.
- The long-press event drives the NIOS reset-request path.
- The press/release pulses are available to a PIO input.

---
 rtl/btn_pkg.sv | 7 +
 rtl/btn_debounce_if.sv | 10 +
 rtl/sync_2ff.sv | 21 ++
 rtl/btn_debounce.sv | 116 +++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM state type and ms-to-cycles helper for the button debouncer
package btn_pkg;
  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} btn_state_t;
  function automatic int cycles_from_ms(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction
endpackage

// File: rtl/btn_debounce_if.sv
// btn_debounce_if: raw button pin in, debounced level and event pulses out
interface btn_debounce_if;
  logic BTN_IN;
  logic BTN_LEVEL;
  logic PRESS_PULSE;
  logic RELEASE_PULSE;
  logic LONG_PRESS;
  modport master (output BTN_IN, input BTN_LEVEL, PRESS_PULSE, RELEASE_PULSE, LONG_PRESS);
  modport slave (input BTN_IN, output BTN_LEVEL, PRESS_PULSE, RELEASE_PULSE, LONG_PRESS);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous pins with a configurable reset level
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end
  assign q = sync_q;
endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: debounced USER_BTN level with single-cycle press/release/long-press pulses
// Long-press counter and LONG_PRESS output exist only when BTN_DEBOUNCE_LONG_PRESS_EN is defined.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int CLK_HZ        = 48000000,
  parameter int DEBOUNCE_MS   = 10,
  parameter int LONG_PRESS_MS = 2000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input logic           CLK48M,
  input logic           RESET,
  btn_debounce_if.slave btn
);
  localparam int DEBOUNCE_CYC = cycles_from_ms(CLK_HZ, DEBOUNCE_MS);
  localparam int DW = $clog2(DEBOUNCE_CYC);
  if (DEBOUNCE_CYC < 2 || LONG_PRESS_MS < 0) begin : g_bad_cfg
    $error("btn_debounce: DEBOUNCE_CYC must be >= 2 and LONG_PRESS_MS non-negative");
  end
  logic btn_sync, btn_s;
  // Synchronizer resets to the released pin level so reset exit cannot fake a press
  sync_2ff #(.RST_VAL(ACTIVE_LOW)) u_sync (
    .clk(CLK48M),
    .rst(RESET),
    .d  (btn.BTN_IN),
    .q  (btn_sync)
  );
  assign btn_s = btn_sync ^ ACTIVE_LOW;
  btn_state_t    state_q, state_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          level_q, level_d, press_q, press_d, release_q, release_d, deb_done;
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    deb_done  = deb_cnt_q == DW'(DEBOUNCE_CYC - 1);
    unique case (state_q)
      RELEASED: begin
        state_d   = btn_s ? PRESS_WAIT : RELEASED;
        deb_cnt_d = '0;
      end
      PRESS_WAIT: begin
        if (!btn_s) state_d = RELEASED;
        else if (deb_done) begin
          state_d = PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
        end else deb_cnt_d = deb_cnt_q + DW'(1);
      end
      PRESSED: begin
        state_d   = btn_s ? PRESSED : RELEASE_WAIT;
        deb_cnt_d = '0;
      end
      RELEASE_WAIT: begin
        if (btn_s) state_d = PRESSED;
        else if (deb_done) begin
          state_d   = RELEASED;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else deb_cnt_d = deb_cnt_q + DW'(1);
      end
      default: state_d = RELEASED;
    endcase
  end
  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) begin
      state_q   <= RELEASED;
      deb_cnt_q <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end
  assign btn.BTN_LEVEL     = level_q;
  assign btn.PRESS_PULSE   = press_q;
  assign btn.RELEASE_PULSE = release_q;
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  localparam int LONG_CYC = cycles_from_ms(CLK_HZ, LONG_PRESS_MS);
  localparam int LW = $clog2(LONG_CYC);
  if (LONG_CYC < 2) begin : g_bad_long
    $error("btn_debounce: LONG_CYC must be >= 2");
  end
  logic [LW-1:0] long_cnt_q, long_cnt_d;
  logic          long_done_q, long_done_d, long_press_q, long_press_d, held, long_max;
  // Counter saturates at its terminal value; long_done blocks a repeat until the next real press
  always_comb begin
    held         = state_q inside {PRESSED, RELEASE_WAIT};
    long_max     = long_cnt_q == LW'(LONG_CYC - 1);
    long_press_d = held && long_max && !long_done_q;
    long_done_d  = press_d ? 1'b0 : long_done_q | long_press_d;
    long_cnt_d   = press_d ? '0 : (held && !long_max) ? long_cnt_q + LW'(1) : long_cnt_q;
  end
  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) begin
      long_cnt_q   <= '0;
      long_done_q  <= 1'b0;
      long_press_q <= 1'b0;
    end else begin
      long_cnt_q   <= long_cnt_d;
      long_done_q  <= long_done_d;
      long_press_q <= long_press_d;
    end
  end
  assign btn.LONG_PRESS = long_press_q;
`else
  assign btn.LONG_PRESS = 1'b0;
`endif
endmodule
